// File: rtl/vga_pkg.sv
// 800x600@60 (40 MHz) video timing constants shared by the VGA datapath.
// Also defines the vertical-blanking window used for board RAM writes.
package vga_pkg;

  localparam int H_ACTIVE      = 800;
  localparam int H_TOTAL_TIME  = 1056;
  localparam int V_ACTIVE      = 600;
  localparam int V_BLANK_START = 600;
  localparam int V_TOTAL_TIME  = 628;

  localparam int DEFAULT_GUARD_LINES = 2;

  localparam int WR_WIN_START = V_BLANK_START;

  // Last line on which a board write may still be issued.
  function automatic int wr_win_end(input int guard_lines);
    return V_TOTAL_TIME - 1 - guard_lines;
  endfunction

  localparam int WR_WIN_END = wr_win_end(DEFAULT_GUARD_LINES);

endpackage

// File: rtl/vblank_write_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request
// at or after rr_ptr, wrapping at NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               valid
);

  localparam int unsigned N = NUM_REQ;

  logic [IDX_W-1:0] sel;

  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    valid      = 1'b0;
    sel        = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sel = IDX_W'((32'(rr_ptr) + k) % N);
      if (!valid && req[sel]) begin
        valid          = 1'b1;
        winner_idx     = sel;
        winner_oh[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vblank_write_scheduler.sv
// Shares the board RAM write port among NUM_REQ requesters, issuing
// round-robin writes only inside vertical blanking, with a per-frame budget.
module vblank_write_scheduler
  import vga_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int ADDR_W           = 7,
  parameter int DATA_W           = 4,
  parameter int GUARD_LINES      = 2,
  parameter int MAX_WR_PER_FRAME = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [10:0]                 vcount,
  input  logic [10:0]                 hcount,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        window_open,
  output logic                        frame_start,
  output logic                        budget_spent
);

  localparam int         IDX_W  = $clog2(NUM_REQ);
  localparam logic [10:0] WIN_LO = 11'(WR_WIN_START);
  localparam logic [10:0] WIN_HI = 11'(wr_win_end(GUARD_LINES));
  localparam logic [7:0]  WR_MAX = 8'(MAX_WR_PER_FRAME);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ARB, WRITE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [7:0]       wr_cnt;

  logic [NUM_REQ-1:0] arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;

  logic issue, budget_hit, win_cond;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .winner_oh  (arb_oh),
    .winner_idx (arb_idx),
    .valid      (arb_valid)
  );

  assign win_cond = (vcount >= WIN_LO) && (vcount <= WIN_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (window_open && !budget_spent) state_nxt = ARB;
      ARB: begin
        if (!window_open || wr_cnt == WR_MAX) state_nxt = IDLE;
        else if (arb_valid)                   state_nxt = WRITE;
      end
      WRITE:   state_nxt = ARB;
      default: state_nxt = IDLE;
    endcase
  end

  // Budget check takes priority over arbitration in ARB.
  always_comb begin
    issue      = 1'b0;
    budget_hit = 1'b0;
    if (state == ARB && window_open) begin
      if (wr_cnt == WR_MAX) budget_hit = 1'b1;
      else if (arb_valid)   issue      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_open <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      window_open <= win_cond;
      frame_start <= (vcount == '0) && (hcount == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rr_ptr    <= '0;
    end else begin
      gnt    <= issue ? arb_oh : '0;
      mem_we <= issue;
      if (issue) begin
        mem_addr  <= req_addr[arb_idx*ADDR_W +: ADDR_W];
        mem_wdata <= req_data[arb_idx*DATA_W +: DATA_W];
        rr_ptr    <= (arb_idx == LAST_IDX) ? '0 : arb_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt       <= '0;
      budget_spent <= 1'b0;
    end else if (frame_start) begin
      wr_cnt       <= '0;
      budget_spent <= 1'b0;
    end else begin
      if (issue)      wr_cnt       <= wr_cnt + 8'd1;
      if (budget_hit) budget_spent <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vblank_write_scheduler.sv
// Directed bench for vblank_write_scheduler: drives vcount/hcount directly
// to jump between active video, blanking window and frame start.
module tb_vblank_write_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] vcount, hcount;
  logic [3:0]  req;
  logic [27:0] req_addr;
  logic [15:0] req_data;
  logic [3:0]  gnt;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [3:0]  mem_wdata;
  logic        window_open, frame_start, budget_spent;

  int tests_run    = 0;
  int tests_failed = 0;
  int n;

  vblank_write_scheduler #(
    .NUM_REQ          (4),
    .ADDR_W           (7),
    .DATA_W           (4),
    .GUARD_LINES      (2),
    .MAX_WR_PER_FRAME (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vcount       (vcount),
    .hcount       (hcount),
    .req          (req),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .gnt          (gnt),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .window_open  (window_open),
    .frame_start  (frame_start),
    .budget_spent (budget_spent)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [6:0] a, input logic [3:0] d);
    req_addr[i*7 +: 7] = a;
    req_data[i*4 +: 4] = d;
  endtask

  task automatic count_writes(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      tick();
      if (mem_we) cnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    int total;
    rst_n  = 1'b0;
    vcount = 11'd300;
    hcount = 11'd0;
    req    = 4'b1111;
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < 4; i++) set_req(i, 7'(10 + i), 4'(i + 1));
    #1;
    check("reset_ctrl", {gnt, mem_we, window_open, frame_start, budget_spent}, 32'h0);
    check("reset_addr", mem_addr, 32'h0);
    check("reset_data", mem_wdata, 32'h0);

    // Reset released mid-frame in active video: no writes.
    tick(); tick();
    rst_n = 1'b1;
    count_writes(8, n);
    check("t1_no_write_active", n, 0);

    vcount = 11'd600;
    tick();
    check("t1_window_open", window_open, 1);
    check("t1_gnt_lat1", gnt, 4'b0000);
    tick();
    check("t1_gnt_lat2", gnt, 4'b0000);
    tick();
    check("t1_first_gnt", gnt, 4'b0001);
    check("t1_first_we", mem_we, 1);
    check("t1_first_addr", mem_addr, 10);
    check("t1_first_data", mem_wdata, 1);

    // All requesters held: rotation 1,2,3,0, one write every other cycle.
    for (int k = 0; k < 4; k++) begin
      w = (k + 1) % 4;
      tick();
      check("t2_gap_gnt", {gnt, mem_we}, 0);
      tick();
      check("t2_gnt", gnt, 32'(1 << w));
      check("t2_addr", mem_addr, 32'(10 + w));
      check("t2_data", mem_wdata, 32'(w + 1));
    end

    // Single request from requester 2.
    req = 4'b0000;
    tick();
    vcount = 11'd610;
    set_req(2, 7'd42, 4'hA);
    req = 4'b0100;
    tick();
    check("t3_gnt", gnt, 4'b0100);
    check("t3_we", mem_we, 1);
    check("t3_addr", mem_addr, 42);
    check("t3_data", mem_wdata, 4'hA);
    req = 4'b0000;
    count_writes(6, n);
    check("t3_no_second_write", n, 0);

    // Frame start, then a full budget of writes.
    vcount = 11'd0;
    hcount = 11'd0;
    tick();
    check("t4_frame_start", frame_start, 1);
    hcount = 11'd1;
    tick();
    check("t4_frame_start_pulse", frame_start, 0);
    vcount = 11'd600;
    hcount = 11'd0;
    set_req(2, 7'd12, 4'h3);
    req = 4'b1111;
    count_writes(200, n);
    check("t4_budget_writes", n, 64);
    check("t4_budget_spent", budget_spent, 1);
    req = 4'b0000;
    vcount = 11'd0;
    hcount = 11'd0;
    tick();
    hcount = 11'd1;
    tick();
    check("t4_budget_cleared", budget_spent, 0);

    // Request on the last cycle of line 625: served, then no writes until next window.
    vcount = 11'd625;
    hcount = 11'd1000;
    tick(); tick();
    hcount = 11'd1055;
    req = 4'b0001;
    tick();
    vcount = 11'd626;
    hcount = 11'd0;
    check("t5_last_gnt", gnt, 4'b0001);
    check("t5_last_addr", mem_addr, 10);
    count_writes(4, total);
    check("t5_window_closed", window_open, 0);
    vcount = 11'd627;
    count_writes(4, n);
    total += n;
    vcount = 11'd0;
    hcount = 11'd0;
    tick();
    if (mem_we) total++;
    hcount = 11'd1;
    vcount = 11'd300;
    count_writes(6, n);
    total += n;
    check("t5_no_write_outside", total, 0);
    vcount = 11'd600;
    hcount = 11'd0;
    tick(); tick(); tick();
    check("t5_next_frame_gnt", gnt, 4'b0001);
    check("t5_next_frame_we", mem_we, 1);

    // Reset during WRITE: outputs clear immediately, arbitration restarts at 0.
    req = 4'b1111;
    #4;
    rst_n = 1'b0;
    #1;
    check("t6_async_gnt", gnt, 4'b0000);
    check("t6_async_we", mem_we, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("t6_restart_gnt", gnt, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
